// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    function automatic int calc_clks_per_bit(input int clock_rate, input int baud_rate);
        return clock_rate / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic arst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!arst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start bit, DATA_WIDTH bits LSB first, one stop bit.
// A validly framed word is presented on q together with a one-cycle dv strobe.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 1_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  data,
    output logic                  dv,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_RATE, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    state_t                state;
    logic [CNT_W-1:0]      clk_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  rx_data;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk (clk),
        .arst(arst),
        .d   (data),
        .q   (rx_data)
    );

    always_ff @(posedge clk) begin
        if (!arst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            q       <= '0;
            dv      <= 1'b0;
        end else begin
            dv <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rx_data) state <= START;
                end
                START: begin
                    // Re-check the line half a bit in so short low glitches are rejected.
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= '0;
                        state   <= rx_data ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt != LAST_CNT) begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end else begin
                        clk_cnt        <= '0;
                        shift[bit_cnt] <= rx_data;
                        if (bit_cnt != LAST_BIT) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (clk_cnt != LAST_CNT) begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end else begin
                        clk_cnt <= '0;
                        // A low stop bit is a framing error: the word is dropped.
                        if (rx_data) begin
                            q  <= shift;
                            dv <= 1'b1;
                        end
                        state <= CLEANUP;
                    end
                end
                CLEANUP: begin
                    dv    <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at default parameters (8 clocks per bit).
module tb_uart_receiver;

    logic       clk;
    logic       arst;
    logic       data;
    logic       dv;
    logic [7:0] q;

    int n_checks = 0;
    int n_errors = 0;

    int         dv_cnt    = 0;
    int         consec_err = 0;
    int         qchg_err  = 0;
    int         x_err     = 0;
    logic [7:0] q_log [0:255];
    logic       prev_dv   = 1'b0;
    logic [7:0] prev_q    = 8'h00;
    logic       prev_arst = 1'b0;
    logic       mon_en    = 1'b0;

    uart_receiver dut (
        .clk (clk),
        .arst(arst),
        .data(data),
        .dv  (dv),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if ($isunknown({dv, q})) x_err <= x_err + 1;
            if (dv === 1'b1) begin
                q_log[dv_cnt % 256] <= q;
                dv_cnt <= dv_cnt + 1;
                if (prev_dv === 1'b1) consec_err <= consec_err + 1;
            end
            if (arst && prev_arst && (q !== prev_q) && (dv !== 1'b1)) qchg_err <= qchg_err + 1;
        end
        prev_dv   <= dv;
        prev_q    <= q;
        prev_arst <= arst;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        data = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            data = b[i];
            tick(8);
        end
        data = stop_bit;
        tick(8);
    endtask

    int base;

    initial begin
        arst = 1'b0;
        data = 1'b1;
        tick(2);
        mon_en = 1'b1;
        check("rst_dv", 32'(dv), 32'h0);
        check("rst_q", 32'(q), 32'h00);
        check("rst_state", 32'(dut.state), 32'h0);
        check("rst_no_x", 32'($isunknown({dv, q})), 32'h0);
        arst = 1'b1;
        tick(4);

        // Single frame 0xA5
        base = dv_cnt;
        send_frame(8'hA5, 1'b1);
        data = 1'b1;
        tick(20);
        check("a5_pulses", 32'(dv_cnt - base), 32'd1);
        check("a5_logged", 32'(q_log[base % 256]), 32'hA5);
        check("a5_hold", 32'(q), 32'hA5);

        // Back-to-back 0x00 then 0xFF
        base = dv_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        data = 1'b1;
        tick(20);
        check("b2b_pulses", 32'(dv_cnt - base), 32'd2);
        check("b2b_first", 32'(q_log[base % 256]), 32'h00);
        check("b2b_second", 32'(q_log[(base + 1) % 256]), 32'hFF);

        // Start-bit glitch
        base = dv_cnt;
        data = 1'b0;
        tick(2);
        data = 1'b1;
        tick(30);
        check("glitch_pulses", 32'(dv_cnt - base), 32'd0);
        check("glitch_q", 32'(q), 32'hFF);
        check("glitch_state", 32'(dut.state), 32'h0);

        // Framing error then a good frame
        base = dv_cnt;
        send_frame(8'h3C, 1'b0);
        data = 1'b1;
        tick(20);
        check("ferr_pulses", 32'(dv_cnt - base), 32'd0);
        check("ferr_q", 32'(q), 32'hFF);
        base = dv_cnt;
        send_frame(8'h81, 1'b1);
        data = 1'b1;
        tick(20);
        check("after_ferr_pulses", 32'(dv_cnt - base), 32'd1);
        check("after_ferr_q", 32'(q), 32'h81);

        // Reset in the middle of frame 0x5A
        data = 1'b0;
        tick(8);
        for (int i = 0; i < 4; i++) begin
            data = (8'h5A >> i) & 8'h01;
            tick(8);
        end
        arst = 1'b0;
        tick(2);
        check("midrst_dv", 32'(dv), 32'h0);
        check("midrst_q", 32'(q), 32'h00);
        check("midrst_state", 32'(dut.state), 32'h0);
        arst = 1'b1;
        data = 1'b1;
        tick(10);
        base = dv_cnt;
        send_frame(8'h12, 1'b1);
        data = 1'b1;
        tick(20);
        check("post_rst_pulses", 32'(dv_cnt - base), 32'd1);
        check("post_rst_q", 32'(q), 32'h12);
        check("post_rst_logged", 32'(q_log[base % 256]), 32'h12);

        // Random line activity
        for (int i = 0; i < 1000; i++) begin
            data = 1'($urandom);
            tick(1);
        end
        data = 1'b1;
        tick(100);
        check("rand_single_pulse", 32'(consec_err), 32'd0);
        check("rand_q_only_with_dv", 32'(qchg_err), 32'd0);
        check("rand_no_x", 32'(x_err), 32'd0);
        check("rand_dv_idle", 32'(dv), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
